// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader.
// RX FSM encodings, default parameters and a byte-lane helper.
package uart_boot_loader_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DEFAULT_CLKS_PER_BIT = 104;
    localparam int DEFAULT_BOOT_WORDS   = 512;
    localparam int DEFAULT_ADDR_W       = 14;

    // Replace byte lane `lane` of `w` with `b` (lane 0 = bits [7:0]).
    function automatic logic [31:0] put_lane(
        input logic [31:0] w,
        input logic [1:0]  lane,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = w;
        unique case (lane)
            2'd0: r[7:0]   = b;
            2'd1: r[15:8]  = b;
            2'd2: r[23:16] = b;
            2'd3: r[31:24] = b;
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_boot_loader_if.sv
// RAM write port driven by the boot loader.
// The loader is the master; the SPRAM boot mux is the slave.
interface uart_boot_loader_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_di;
    logic              ram_we;

    modport master (
        output ram_addr,
        output ram_di,
        output ram_we
    );

    modport slave (
        input ram_addr,
        input ram_di,
        input ram_we
    );
endinterface

// File: rtl/uart_boot_loader_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, bit timer and RX FSM.
// Emits one-cycle rx_valid / rx_ferr strobes at the stop-bit centre.
module uart_rx_byte
    import uart_boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       en,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    logic          sync1_q, sync2_q;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    // Bring the asynchronous line into the clk domain; a cleared
    // synchronizer only causes a false start that the START check drops.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
        end
    end

    // RX FSM next state: centre-sample start, eight data bits and stop.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    timer_d = '0;
                    if (!sync2_q) begin
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    if (timer_q == T_HALF) begin
                        timer_d = '0;
                        if (sync2_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            bit_d   = 3'd0;
                        end
                    end else begin
                        timer_d = timer_q + T_ONE;
                    end
                end
                ST_DATA: begin
                    if (timer_q == T_FULL) begin
                        timer_d = '0;
                        shift_d = {sync2_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        timer_d = timer_q + T_ONE;
                    end
                end
                ST_STOP: begin
                    if (timer_q == T_FULL) begin
                        timer_d = '0;
                        state_d = ST_IDLE;
                        valid_d = sync2_q;
                        ferr_d  = !sync2_q;
                    end else begin
                        timer_d = timer_q + T_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // RX FSM state, timer, shift register and strobes.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data  = shift_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: packs received bytes little-endian into words,
// writes them to sequential RAM addresses and raises boot when done.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int WORDS        = DEFAULT_BOOT_WORDS,
    parameter int ADDR_W       = DEFAULT_ADDR_W
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  uart_rx,
    uart_boot_loader_if.master    ram,
    output logic                  boot,
    output logic                  frame_err,
    output logic [1:0]            byte_cnt
);

    localparam int IW = ADDR_W + 1;
    localparam logic [ADDR_W:0] LAST_IDX = IW'(WORDS - 1);
    localparam logic [ADDR_W:0] IDX_ONE  = IW'(1);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;

    logic [31:0]       shadow_q, shadow_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       di_q, di_d;
    logic              we_q, we_d;
    logic              boot_q, boot_d;
    logic              ferr_q, ferr_d;
    logic              take;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .resetb   (resetb),
        .en       (!boot_q),
        .uart_rx  (uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    assign take = rx_valid && !boot_q;

    // Lane packing, word write, index advance and completion flag.
    always_comb begin
        shadow_d   = shadow_q;
        byte_cnt_d = byte_cnt_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        di_d       = di_q;
        we_d       = 1'b0;
        boot_d     = boot_q;
        ferr_d     = ferr_q;
        if (take) begin
            shadow_d   = put_lane(shadow_q, byte_cnt_q, rx_data);
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
                we_d   = 1'b1;
                di_d   = put_lane(shadow_q, 2'd3, rx_data);
                addr_d = idx_q[ADDR_W-1:0];
            end
        end
        if (rx_ferr && !boot_q) begin
            ferr_d = 1'b1;
        end
        if (we_q) begin
            idx_d = idx_q + IDX_ONE;
            if (idx_q == LAST_IDX) begin
                boot_d = 1'b1;
            end
        end
    end

    // Word assembly, RAM port and status registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            shadow_q   <= 32'd0;
            byte_cnt_q <= 2'd0;
            idx_q      <= '0;
            addr_q     <= '0;
            di_q       <= 32'd0;
            we_q       <= 1'b0;
            boot_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            byte_cnt_q <= byte_cnt_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            di_q       <= di_d;
            we_q       <= we_d;
            boot_q     <= boot_d;
            ferr_q     <= ferr_d;
        end
    end

    assign ram.ram_addr = addr_q;
    assign ram.ram_di   = di_q;
    assign ram.ram_we   = we_q;
    assign boot         = boot_q;
    assign frame_err    = ferr_q;
    assign byte_cnt     = byte_cnt_q;

endmodule
